instr_encoder_loader: RTL

Encodes MIPS instruction fields (R/I/J formats) into 32-bit words and writes them to consecutive instruction-memory word addresses. It accepts beats over a valid/ready handshake. It holds the CPU in reset while a program is loading and releases it once loading completes. It is the field-to-word counterpart of the opcode decoder and feeds the instruction memory used by the single-cycle and pipelined cores.

---
 rtl/instr_enc_pkg.sv | 36 +++
 rtl/instr_word_encoder.sv | 44 ++++
 rtl/instr_encoder_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the instruction encoder/loader:
// instruction formats, MIPS opcodes, loader states and error-bit positions.
package instr_enc_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ERR_FMT      = 0;
    localparam int ERR_MISMATCH = 1;
    localparam int ERR_FULL     = 2;

    // Opcodes that only make sense in the J format.
    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational field-to-word encoder for MIPS R/I/J formats.
// Flags the illegal format code and opcodes that do not belong to the format.
module instr_word_encoder
    import instr_enc_pkg::*;
(
    input  logic [1:0]  fmt_s,
    input  logic [5:0]  op_s,
    input  logic [4:0]  rs_s,
    input  logic [4:0]  rt_s,
    input  logic [4:0]  rd_s,
    input  logic [4:0]  shamt_s,
    input  logic [5:0]  funct_s,
    input  logic [15:0] imm_s,
    input  logic [25:0] target_s,
    output logic [31:0] word_s,
    output logic        illegal_s,
    output logic        mismatch_s
);

    // Pack the fields of the selected format and classify the opcode.
    always_comb begin
        word_s     = 32'h0;
        illegal_s  = 1'b0;
        mismatch_s = 1'b0;
        case (fmt_s)
            FMT_R: begin
                word_s     = {op_s, rs_s, rt_s, rd_s, shamt_s, funct_s};
                mismatch_s = (op_s != OP_RTYPE);
            end
            FMT_I: begin
                word_s     = {op_s, rs_s, rt_s, imm_s};
                mismatch_s = (op_s == OP_RTYPE) || is_jump_op(op_s);
            end
            FMT_J: begin
                word_s     = {op_s, target_s};
                mismatch_s = !is_jump_op(op_s);
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts instruction-field beats, encodes them and writes
// them to consecutive instruction-memory words while holding the CPU in reset.
// Optional running XOR checksum of written words: define ENC_CHECKSUM_EN.
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              last_i,
    input  logic [1:0]        fmt_i,
    input  logic [5:0]        op_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cpu_hold_o,
    output logic [2:0]        err_o,
    output logic [31:0]       checksum_o
);

    state_e            state_r, state_nxt_s;
    logic              load_r, done_r, hold_r;
    logic [ADDR_W-1:0] ptr_r, ptr_nxt_s;
    logic [ADDR_W:0]   count_r, count_nxt_s;
    logic [2:0]        err_r, err_nxt_s;
    logic              we_r, we_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [31:0]       wdata_r, wdata_nxt_s;
    logic [31:0]       enc_word_s;
    logic              enc_illegal_s, enc_mismatch_s;
    logic              full_s;

    instr_word_encoder u_enc (
        .fmt_s      (fmt_i),
        .op_s       (op_i),
        .rs_s       (rs_i),
        .rt_s       (rt_i),
        .rd_s       (rd_i),
        .shamt_s    (shamt_i),
        .funct_s    (funct_i),
        .imm_s      (imm_i),
        .target_s   (target_i),
        .word_s     (enc_word_s),
        .illegal_s  (enc_illegal_s),
        .mismatch_s (enc_mismatch_s)
    );

    // The current beat would land on the last memory word.
    assign full_s = (ptr_r == {ADDR_W{1'b1}});

    // Next state, write scheduling, pointer/count and sticky error update.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        count_nxt_s = count_r;
        err_nxt_s   = err_r;
        we_nxt_s    = 1'b0;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        if (start_i) begin
            // Start wins over any beat presented in the same cycle.
            state_nxt_s = ST_LOAD;
            ptr_nxt_s   = {ADDR_W{1'b0}};
            count_nxt_s = {(ADDR_W+1){1'b0}};
            err_nxt_s   = 3'b000;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (valid_i) begin
                        if (enc_illegal_s) begin
                            err_nxt_s[ERR_FMT] = 1'b1;
                            state_nxt_s        = last_i ? ST_DONE : ST_LOAD;
                        end else begin
                            we_nxt_s    = 1'b1;
                            addr_nxt_s  = ptr_r;
                            wdata_nxt_s = enc_word_s;
                            ptr_nxt_s   = ptr_r + ADDR_W'(1);
                            count_nxt_s = count_r + (ADDR_W+1)'(1);
                            err_nxt_s[ERR_MISMATCH] = err_r[ERR_MISMATCH] | enc_mismatch_s;
                            err_nxt_s[ERR_FULL]     = err_r[ERR_FULL] | (full_s & ~last_i);
                            state_nxt_s = (last_i || full_s) ? ST_DONE : ST_LOAD;
                        end
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_DONE: state_nxt_s = ST_DONE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register plus registered status outputs decoded from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            load_r  <= 1'b0;
            done_r  <= 1'b0;
            hold_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            load_r  <= (state_nxt_s == ST_LOAD);
            done_r  <= (state_nxt_s == ST_DONE);
            hold_r  <= (state_nxt_s != ST_DONE);
        end
    end

    // Datapath registers: pointer, count, errors and the memory write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_r   <= {ADDR_W{1'b0}};
            count_r <= {(ADDR_W+1){1'b0}};
            err_r   <= 3'b000;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 32'h0;
        end else begin
            ptr_r   <= ptr_nxt_s;
            count_r <= count_nxt_s;
            err_r   <= err_nxt_s;
            we_r    <= we_nxt_s;
            addr_r  <= addr_nxt_s;
            wdata_r <= wdata_nxt_s;
        end
    end

`ifdef ENC_CHECKSUM_EN
    logic [31:0] csum_r, csum_nxt_s;

    // Fold each scheduled write into the running checksum; start clears it.
    always_comb begin
        csum_nxt_s = csum_r;
        if (start_i) begin
            csum_nxt_s = 32'h0;
        end else if (we_nxt_s) begin
            csum_nxt_s = csum_r ^ wdata_nxt_s;
        end else begin
            csum_nxt_s = csum_r;
        end
    end

    // Checksum register, updated together with the write strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_r <= 32'h0;
        end else begin
            csum_r <= csum_nxt_s;
        end
    end

    assign checksum_o = csum_r;
`else
    assign checksum_o = 32'h0;
`endif

    assign ready_o      = load_r;
    assign busy_o       = load_r;
    assign done_o       = done_r;
    assign cpu_hold_o   = hold_r;
    assign count_o      = count_r;
    assign err_o        = err_r;
    assign imem_we_o    = we_r;
    assign imem_addr_o  = addr_r;
    assign imem_wdata_o = wdata_r;

endmodule
